// File: rtl/jpeg_stream_writer.sv
// rtl/jpeg_stream_writer.sv - packs byte-stuffed JPEG output into 32-bit words written over Avalon-MM
// Optional feature macro: JPEG_EOI_EN (append 0xFF,0xD9 end-of-image marker on flush)
module jpeg_stream_writer #(
    parameter int ADDR_W  = 32,
    parameter int COUNT_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [15:0]        in_bits,
    input  logic [1:0]         in_valid,
    input  logic               ena_in,
    output logic               rdy_out,
    input  logic               flush,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [31:0]        wr_data,
    output logic [3:0]         wr_byteen,
    output logic               wr_req,
    input  logic               wr_waitrequest,
    output logic [COUNT_W-1:0] byte_count,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_FLUSH,
        S_PARTIAL,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  byte_buf [5];
    logic [2:0]  cnt;
    logic [2:0]  cnt_p1;
    logic        flush_pend;
    logic        accept;
    logic [31:0] partial_data;
    logic [3:0]  partial_be;
`ifdef JPEG_EOI_EN
    logic        eoi_added;
`endif

    assign rdy_out = (state == S_FILL) && !flush_pend && (cnt <= 3'd3);
    assign accept  = ena_in && rdy_out;
    assign done    = (state == S_DONE);
    assign cnt_p1  = cnt + 3'd1;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_FILL;
            S_FILL: begin
                if (cnt >= 3'd4)     state_next = S_WRITE;
                else if (flush_pend) state_next = S_FLUSH;
            end
            S_WRITE:   if (!wr_waitrequest) state_next = S_FILL;
            S_FLUSH: begin
                if (cnt != 3'd0) state_next = S_PARTIAL;
                else             state_next = S_DONE;
`ifdef JPEG_EOI_EN
                // First flush only appends the marker; it is then drained like normal data
                if (!eoi_added) state_next = S_FILL;
`endif
            end
            S_PARTIAL: if (!wr_waitrequest) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Tail word: bytes beyond the buffered count are forced to zero
    always_comb begin
        partial_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < cnt) partial_data[8*i +: 8] = byte_buf[i];
        end
        case (cnt)
            3'd0:    partial_be = 4'h0;
            3'd1:    partial_be = 4'h1;
            3'd2:    partial_be = 4'h3;
            3'd3:    partial_be = 4'h7;
            default: partial_be = 4'hF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_byteen  <= '0;
            byte_count <= '0;
            err        <= 1'b0;
            for (int i = 0; i < 5; i++) byte_buf[i] <= '0;
`ifdef JPEG_EOI_EN
            eoi_added  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state != S_IDLE && flush) flush_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wr_addr    <= base_addr & ~ADDR_W'(3);
                        cnt        <= '0;
                        byte_count <= '0;
                        err        <= 1'b0;
`ifdef JPEG_EOI_EN
                        eoi_added  <= 1'b0;
`endif
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        case (in_valid)
                            2'd2: begin
                                byte_buf[cnt]    <= in_bits[15:8];
                                byte_buf[cnt_p1] <= in_bits[7:0];
                                cnt              <= cnt + 3'd2;
                            end
                            2'd1: begin
                                byte_buf[cnt] <= in_bits[15:8];
                                cnt           <= cnt_p1;
                            end
                            2'd3:    err <= 1'b1;
                            default: ;
                        endcase
                    end
                    if (state_next == S_WRITE) begin
                        wr_req    <= 1'b1;
                        wr_data   <= {byte_buf[3], byte_buf[2], byte_buf[1], byte_buf[0]};
                        wr_byteen <= 4'hF;
                    end
                end
                S_WRITE: begin
                    if (!wr_waitrequest) begin
                        wr_req      <= 1'b0;
                        byte_buf[0] <= byte_buf[4];
                        for (int i = 1; i < 5; i++) byte_buf[i] <= '0;
                        cnt         <= cnt - 3'd4;
                        wr_addr     <= wr_addr + ADDR_W'(4);
                        byte_count  <= byte_count + COUNT_W'(4);
                    end
                end
                S_FLUSH: begin
                    if (state_next == S_PARTIAL) begin
                        wr_req    <= 1'b1;
                        wr_data   <= partial_data;
                        wr_byteen <= partial_be;
                    end
`ifdef JPEG_EOI_EN
                    if (state_next == S_FILL) begin
                        byte_buf[cnt]    <= 8'hFF;
                        byte_buf[cnt_p1] <= 8'hD9;
                        cnt              <= cnt + 3'd2;
                        eoi_added        <= 1'b1;
                    end
`endif
                end
                S_PARTIAL: begin
                    if (!wr_waitrequest) begin
                        wr_req     <= 1'b0;
                        byte_count <= byte_count + COUNT_W'(cnt);
                        cnt        <= '0;
                    end
                end
                S_DONE:  flush_pend <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_stream_writer.sv
// tb/tb_jpeg_stream_writer.sv - directed self-checking bench for jpeg_stream_writer
module tb_jpeg_stream_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] in_bits;
    logic [1:0]  in_valid;
    logic        ena_in;
    logic        rdy_out;
    logic        flush;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byteen;
    logic        wr_req;
    logic        wr_waitrequest;
    logic [23:0] byte_count;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    jpeg_stream_writer #(.ADDR_W(32), .COUNT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_bits(in_bits), .in_valid(in_valid), .ena_in(ena_in), .rdy_out(rdy_out),
        .flush(flush), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byteen(wr_byteen),
        .wr_req(wr_req), .wr_waitrequest(wr_waitrequest), .byte_count(byte_count),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] b, input logic [1:0] v);
        int n = 0;
        ena_in = 1'b1; in_bits = b; in_valid = v;
        while (!rdy_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_seen", (n < 20), 1);
        @(negedge clk);
        ena_in = 1'b0;
    endtask

    task automatic wait_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        int n = 0;
        while (!wr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, wr_req, 1);
        check({tag, "_addr"}, wr_addr, a);
        check({tag, "_data"}, wr_data, d);
        check({tag, "_be"}, wr_byteen, be);
        @(negedge clk);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic do_start(input logic [31:0] base);
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_bits = '0; in_valid = '0;
        ena_in = 1'b0; flush = 1'b0; wr_waitrequest = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_byteen", wr_byteen, 0);
        check("rst_byte_count", byte_count, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdy", rdy_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: three transfers, one full word, 0x55 left over
        do_start(32'h0000_1000);
        check("t1_rdy_after_start", rdy_out, 1);
        check("t1_addr_latched", wr_addr, 32'h1000);
        send(16'h1122, 2'd2);
        send(16'h3300, 2'd1);
        send(16'h4455, 2'd2);
        check("t1_req_not_yet", wr_req, 0);
        check("t1_rdy_full", rdy_out, 0);
        @(negedge clk);
        check("t1_req_latency", wr_req, 1);
        check("t1_addr", wr_addr, 32'h1000);
        check("t1_data", wr_data, 32'h4433_2211);
        check("t1_be", wr_byteen, 4'hF);
        @(negedge clk);
        check("t1_req_dropped", wr_req, 0);
        check("t1_byte_count", byte_count, 4);
        check("t1_next_addr", wr_addr, 32'h1004);

        // Test 2/3: flush the held byte
        pulse_flush();
        check("t2_rdy_after_flush", rdy_out, 0);
        check("t2_no_early_done", done, 0);
`ifdef JPEG_EOI_EN
        wait_write("t3_tail", 32'h1004, 32'h00D9_FF55, 4'h7);
        wait_done("t3");
        check("t3_byte_count", byte_count, 7);
`else
        wait_write("t2_tail", 32'h1004, 32'h0000_0055, 4'h1);
        wait_done("t2");
        check("t2_byte_count", byte_count, 5);
`endif
        @(negedge clk);
        check("t2_done_pulse_one_cycle", done, 0);
        check("t2_idle_rdy", rdy_out, 0);

        // Test 4: stalled WRITE, ignored start, held ena_in
        wr_waitrequest = 1'b1;
        do_start(32'h0000_3000);
        send(16'hA1A2, 2'd2);
        send(16'hA3A4, 2'd2);
        @(negedge clk);
        check("t4_req", wr_req, 1);
        ena_in = 1'b1; in_bits = 16'hB1B2; in_valid = 2'd2;
        start = 1'b1; base_addr = 32'h0000_9000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("t4_stall_req", wr_req, 1);
            check("t4_stall_addr", wr_addr, 32'h3000);
            check("t4_stall_data", wr_data, 32'hA4A3_A2A1);
            check("t4_stall_be", wr_byteen, 4'hF);
            check("t4_stall_rdy", rdy_out, 0);
        end
        wr_waitrequest = 1'b0;
        send(16'hB1B2, 2'd2);
        send(16'hC1C2, 2'd2);
        wait_write("t4_second", 32'h3004, 32'hC2C1_B2B1, 4'hF);
        check("t4_byte_count", byte_count, 8);
        pulse_flush();
`ifdef JPEG_EOI_EN
        wait_write("t4_eoi", 32'h3008, 32'h0000_D9FF, 4'h3);
        wait_done("t4");
        check("t4_final_count", byte_count, 10);
`else
        wait_done("t4");
        check("t4_final_count", byte_count, 8);
`endif
        @(negedge clk);

        // Test 5: reserved in_valid sets sticky err, buffer untouched
        do_start(32'h0000_2003);
        check("t5_addr_aligned", wr_addr, 32'h2000);
        check("t5_err_clear", err, 0);
        send(16'h7777, 2'd3);
        check("t5_err_set", err, 1);
        send(16'h0102, 2'd2);
        send(16'h0304, 2'd2);
        wait_write("t5_word", 32'h2000, 32'h0403_0201, 4'hF);
        check("t5_err_sticky", err, 1);
        pulse_flush();
`ifdef JPEG_EOI_EN
        wait_write("t5_eoi", 32'h2004, 32'h0000_D9FF, 4'h3);
        wait_done("t5");
        check("t5_byte_count", byte_count, 6);
`else
        wait_done("t5");
        check("t5_byte_count", byte_count, 4);
`endif
        @(negedge clk);
        do_start(32'h0000_5000);
        check("t5_err_cleared_by_start", err, 0);
        check("t5_new_base", wr_addr, 32'h5000);

        // Test 6: async reset in the middle of a stalled WRITE
        send(16'h7777, 2'd3);
        wr_waitrequest = 1'b1;
        send(16'h1111, 2'd2);
        send(16'h2222, 2'd2);
        @(negedge clk);
        check("t6_req_before_rst", wr_req, 1);
        check("t6_err_before_rst", err, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_req", wr_req, 0);
        check("t6_rst_wr_addr", wr_addr, 0);
        check("t6_rst_wr_data", wr_data, 0);
        check("t6_rst_wr_byteen", wr_byteen, 0);
        check("t6_rst_byte_count", byte_count, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_rdy", rdy_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_waitrequest = 1'b0;
        ena_in = 1'b1; in_bits = 16'h1234; in_valid = 2'd2;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flush = 1'b0;
            check("t6_idle_rdy", rdy_out, 0);
            check("t6_idle_req", wr_req, 0);
        end
        ena_in = 1'b0;
        do_start(32'h0000_6000);
        check("t6_rdy_after_start", rdy_out, 1);
        @(negedge clk);
        check("t6_idle_flush_ignored", rdy_out, 1);
        check("t6_count_zero", byte_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
